// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: opcode masks, DDRAM address map and the 2x16 character array type.
package lcd_pkg;

  localparam logic [7:0] INSTR_CLEAR     = 8'h01;
  localparam logic [7:0] INSTR_HOME      = 8'h02;
  localparam logic [7:0] INSTR_ENTRY     = 8'h04;
  localparam logic [7:0] INSTR_DISPLAY   = 8'h08;
  localparam logic [7:0] INSTR_SHIFT     = 8'h10;
  localparam logic [7:0] INSTR_FUNCTION  = 8'h20;
  localparam logic [7:0] INSTR_SET_CGRAM = 8'h40;
  localparam logic [7:0] INSTR_SET_DDRAM = 8'h80;

  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam logic [6:0] ROW0_BASE   = 7'h00;
  localparam logic [6:0] ROW1_BASE   = 7'h40;
  localparam logic [6:0] LINE_END    = 7'h27;
  localparam logic [6:0] LINE1_END   = ROW1_BASE | LINE_END;
  localparam int         ROW_VISIBLE = 16;
  localparam int         NUM_ROWS    = 2;

  typedef logic [7:0] char_array_t [NUM_ROWS-1:0][ROW_VISIBLE-1:0];

  typedef enum logic {
    SWEEP_IDLE,
    SWEEP_CLEAR
  } sweep_state_t;

  function automatic logic has_bit(input logic [7:0] d, input logic [7:0] mask);
    return |(d & mask);
  endfunction

  // Visible cells are 0x00-0x0F and 0x40-0x4F: bits 5:4 clear in both ranges.
  function automatic logic addr_visible(input logic [6:0] a);
    return a[5:4] == 2'b00;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_addr_step.sv
// Next DDRAM address for the 2-line map, wrapping 0x27<->0x40 and 0x67<->0x00.
module lcd_addr_step
  import lcd_pkg::*;
(
  input  logic [6:0] addr,
  input  logic       increment,
  output logic [6:0] next_addr
);

  always_comb begin
    next_addr = increment ? (addr + 7'd1) : (addr - 7'd1);
    if (increment) begin
      if (addr == LINE_END)
        next_addr = ROW1_BASE;
      else if (addr == LINE1_END)
        next_addr = ROW0_BASE;
    end else begin
      if (addr == ROW1_BASE)
        next_addr = LINE_END;
      else if (addr == ROW0_BASE)
        next_addr = LINE1_END;
    end
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780 8-bit bus responder keeping a 2x16 character buffer and display-control state.
// Optional macro LCD_RESP_BUSY_TIMING_EN adds instruction/data busy timing.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int EXEC_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] characters [1:0][15:0],
  output logic [6:0] addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       overrun,
  output logic       wr_strobe
);

  logic         en_q_reg;
  logic         rs_q_reg;
  logic [7:0]   data_q_reg;
  logic         en_fall;
  logic         accept;

  logic [6:0]   addr_reg, addr_next;
  logic         id_reg, id_next;
  logic         display_on_reg, display_on_next;
  logic         cursor_on_reg, cursor_on_next;
  logic         blink_on_reg, blink_on_next;
  logic         cgram_reg, cgram_next;
  logic         overrun_reg;
  logic         wr_strobe_reg;
  logic         data_wr;

  sweep_state_t state_reg, state_next;
  logic [4:0]   idx_reg, idx_next;
  logic         sweep_wr;
  logic         sweeping;
  logic         is_clear;

  char_array_t  chars_reg;

  logic         step_dir;
  logic [6:0]   step_addr;

  // Bus capture: data is held from the last cycle EN was high.
  always_ff @(posedge CLOCK_50) begin
    en_q_reg <= LCD_EN;
    if (LCD_EN) begin
      rs_q_reg   <= LCD_RS;
      data_q_reg <= LCD_DATA;
    end
  end

  assign en_fall  = en_q_reg & ~LCD_EN;
  assign accept   = en_fall & ~busy;
  assign is_clear = accept & ~rs_q_reg & (data_q_reg == INSTR_CLEAR);

  // Data writes follow I/D; cursor shift uses the R/L bit of the instruction.
  assign step_dir = rs_q_reg ? id_reg : data_q_reg[2];

  lcd_addr_step u_addr_step (
    .addr      (addr_reg),
    .increment (step_dir),
    .next_addr (step_addr)
  );

  // Clear sweep: one cell per cycle, row 0 then row 1.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_reg <= SWEEP_IDLE;
      idx_reg   <= 5'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    sweep_wr   = 1'b0;
    case (state_reg)
      SWEEP_IDLE: begin
        if (is_clear) begin
          state_next = SWEEP_CLEAR;
          idx_next   = 5'd0;
        end
      end
      SWEEP_CLEAR: begin
        sweep_wr = 1'b1;
        if (idx_reg == 5'd31)
          state_next = SWEEP_IDLE;
        else
          idx_next = idx_reg + 5'd1;
      end
      default: state_next = SWEEP_IDLE;
    endcase
  end

  assign sweeping = (state_reg == SWEEP_CLEAR);

  // Transaction decode; for instructions the highest set bit selects the command.
  always_comb begin
    addr_next       = addr_reg;
    id_next         = id_reg;
    display_on_next = display_on_reg;
    cursor_on_next  = cursor_on_reg;
    blink_on_next   = blink_on_reg;
    cgram_next      = cgram_reg;
    data_wr         = 1'b0;
    if (accept) begin
      if (rs_q_reg) begin
        if (!cgram_reg) begin
          data_wr   = addr_visible(addr_reg);
          addr_next = step_addr;
        end
      end else if (has_bit(data_q_reg, INSTR_SET_DDRAM)) begin
        addr_next  = data_q_reg[6:0];
        cgram_next = 1'b0;
      end else if (has_bit(data_q_reg, INSTR_SET_CGRAM)) begin
        cgram_next = 1'b1;
      end else if (has_bit(data_q_reg, INSTR_FUNCTION)) begin
        // Only 8-bit, 2-line operation exists; nothing to record.
        addr_next = addr_reg;
      end else if (has_bit(data_q_reg, INSTR_SHIFT)) begin
        if (!data_q_reg[3])
          addr_next = step_addr;
      end else if (has_bit(data_q_reg, INSTR_DISPLAY)) begin
        display_on_next = data_q_reg[2];
        cursor_on_next  = data_q_reg[1];
        blink_on_next   = data_q_reg[0];
      end else if (has_bit(data_q_reg, INSTR_ENTRY)) begin
        id_next = data_q_reg[1];
      end else if (has_bit(data_q_reg, INSTR_HOME)) begin
        addr_next = ROW0_BASE;
      end else if (has_bit(data_q_reg, INSTR_CLEAR)) begin
        addr_next = ROW0_BASE;
        id_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      addr_reg       <= ROW0_BASE;
      id_reg         <= 1'b1;
      display_on_reg <= 1'b0;
      cursor_on_reg  <= 1'b0;
      blink_on_reg   <= 1'b0;
      cgram_reg      <= 1'b0;
      overrun_reg    <= 1'b0;
      wr_strobe_reg  <= 1'b0;
    end else begin
      addr_reg       <= addr_next;
      id_reg         <= id_next;
      display_on_reg <= display_on_next;
      cursor_on_reg  <= cursor_on_next;
      blink_on_reg   <= blink_on_next;
      cgram_reg      <= cgram_next;
      wr_strobe_reg  <= accept;
      if (en_fall && busy)
        overrun_reg <= 1'b1;
    end
  end

  // Sweep and data writes never coincide: data is refused while sweeping.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < ROW_VISIBLE; c++)
          chars_reg[r][c] <= BLANK_CHAR;
    end else if (sweep_wr) begin
      chars_reg[idx_reg[4]][idx_reg[3:0]] <= BLANK_CHAR;
    end else if (data_wr) begin
      chars_reg[addr_reg[6]][addr_reg[3:0]] <= data_q_reg;
    end
  end

`ifdef LCD_RESP_BUSY_TIMING_EN
  localparam int BUSY_MAX = max_int(EXEC_CYCLES, CLEAR_CYCLES);
  localparam int BUSY_W   = $clog2(BUSY_MAX + 1);

  logic [BUSY_W-1:0] busy_cnt_reg;
  logic              long_instr;

  assign long_instr = ~rs_q_reg & (data_q_reg[7:2] == 6'd0) & (data_q_reg[1:0] != 2'd0);

  always_ff @(posedge CLOCK_50) begin
    if (Reset)
      busy_cnt_reg <= '0;
    else if (accept)
      busy_cnt_reg <= long_instr ? BUSY_W'(CLEAR_CYCLES) : BUSY_W'(EXEC_CYCLES);
    else if (busy_cnt_reg != '0)
      busy_cnt_reg <= busy_cnt_reg - BUSY_W'(1);
  end

  // A clear stays busy until both the counter and the sweep are done.
  assign busy = sweeping | (busy_cnt_reg != '0);
`else
  logic unused_timing_params;
  assign unused_timing_params = ^{EXEC_CYCLES, CLEAR_CYCLES};
  assign busy = sweeping;
`endif

  assign characters = chars_reg;
  assign addr       = addr_reg;
  assign display_on = display_on_reg;
  assign cursor_on  = cursor_on_reg;
  assign blink_on   = blink_on_reg;
  assign overrun    = overrun_reg;
  assign wr_strobe  = wr_strobe_reg;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder; honours LCD_RESP_BUSY_TIMING_EN when defined.
module tb_lcd_hd44780_responder;

  localparam int EXEC_T  = 10;
  localparam int CLEAR_T = 40;
`ifdef LCD_RESP_BUSY_TIMING_EN
  localparam int CLEAR_BUSY = CLEAR_T;
`else
  localparam int CLEAR_BUSY = 32;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       Reset;
  logic       LCD_EN;
  logic       LCD_RS;
  logic [7:0] LCD_DATA;
  logic [7:0] characters [1:0][15:0];
  logic [6:0] addr;
  logic       display_on, cursor_on, blink_on, busy, overrun, wr_strobe;

  int checks = 0;
  int errors = 0;
  int bcount;
  int bad;
  logic ws_seen;

  lcd_hd44780_responder #(
    .EXEC_CYCLES  (EXEC_T),
    .CLEAR_CYCLES (CLEAR_T)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .Reset      (Reset),
    .LCD_EN     (LCD_EN),
    .LCD_RS     (LCD_RS),
    .LCD_DATA   (LCD_DATA),
    .characters (characters),
    .addr       (addr),
    .display_on (display_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .busy       (busy),
    .overrun    (overrun),
    .wr_strobe  (wr_strobe)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    if (n != 0) check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  // One bus transaction; returns one cycle after the executing edge.
  task automatic send(input logic rs, input logic [7:0] d);
    wait_idle();
    @(posedge CLOCK_50); #1;
    LCD_RS = rs; LCD_DATA = d; LCD_EN = 1'b1;
    @(posedge CLOCK_50); #1;
    LCD_EN = 1'b0;
    @(posedge CLOCK_50); #1;
    $display("txn rs=%0b data=%02h addr=%02h busy=%0b", rs, d, addr, busy);
  endtask

  task automatic count_non_blank(output int cnt);
    cnt = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++)
        if (characters[r][c] !== 8'h20) cnt++;
  endtask

  initial begin
    Reset = 1'b1; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_DATA = 8'h00;
    repeat (3) @(posedge CLOCK_50);
    #1 Reset = 1'b0;
    count_non_blank(bad);
    check("reset_blank_cells", bad, 0);
    check("reset_addr", addr, 7'h00);
    check("reset_display_on", display_on, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_wr_strobe", wr_strobe, 0);

    // Basic init and two characters
    send(0, 8'h38); send(0, 8'h0C); send(0, 8'h06); send(0, 8'h80);
    send(1, 8'h41); send(1, 8'h42);
    check("wr_strobe_pulse", wr_strobe, 1);
    @(posedge CLOCK_50); #1;
    check("wr_strobe_one_cycle", wr_strobe, 0);
    check("char_0_0_A", characters[0][0], 8'h41);
    check("char_0_1_B", characters[0][1], 8'h42);
    check("addr_after_AB", addr, 7'h02);
    check("display_on", display_on, 1);
    check("cursor_off", cursor_on, 0);

    // Row 1 and end of row 0 with invisible spill
    send(0, 8'hC0); send(1, 8'h5A);
    check("char_1_0", characters[1][0], 8'h5A);
    check("addr_0x41", addr, 7'h41);
    send(0, 8'h8F); send(1, 8'h31); send(1, 8'h32);
    check("char_0_15", characters[0][15], 8'h31);
    check("addr_0x11", addr, 7'h11);

    // Line-end wrap and decrement wrap
    send(0, 8'hA7); send(1, 8'h55);
    check("wrap_27_to_40", addr, 7'h40);
    check("char_1_0_kept", characters[1][0], 8'h5A);
    send(0, 8'h80); send(0, 8'h04); send(1, 8'h58);
    check("char_0_0_X", characters[0][0], 8'h58);
    check("wrap_00_to_67", addr, 7'h67);
    send(0, 8'h14);
    check("shift_inc_67_to_00", addr, 7'h00);
    send(0, 8'h10);
    check("shift_dec_00_to_67", addr, 7'h67);
    send(0, 8'h0F);
    check("blink_on", blink_on, 1);
    check("cursor_on", cursor_on, 1);

    // CGRAM mode swallows data
    send(0, 8'h40); send(1, 8'h77);
    check("cgram_addr_hold", addr, 7'h67);
    send(0, 8'h8A); send(0, 8'h02);
    check("home_addr", addr, 7'h00);
    send(0, 8'h00);
    check("noop_wr_strobe", wr_strobe, 1);

    // Fill buffer then clear with a colliding transaction
    send(0, 8'h80); send(0, 8'h06);
    for (int c = 0; c < 16; c++) send(1, 8'h30 + 8'(c));
    send(0, 8'hC0);
    for (int c = 0; c < 16; c++) send(1, 8'h60 + 8'(c));
    check("fill_0_5", characters[0][5], 8'h35);
    check("fill_1_15", characters[1][15], 8'h6F);
    check("fill_addr", addr, 7'h50);
    send(0, 8'h01);
    check("clear_busy_start", busy, 1);
    bcount = 1; ws_seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 5) begin LCD_RS = 1'b1; LCD_DATA = 8'h99; LCD_EN = 1'b1; end
      if (i == 6) LCD_EN = 1'b0;
      @(posedge CLOCK_50); #1;
      if (wr_strobe) ws_seen = 1'b1;
      if (!busy) break;
      bcount++;
    end
    check("clear_busy_cycles", bcount, CLEAR_BUSY);
    check("clear_no_strobe", ws_seen, 0);
    count_non_blank(bad);
    check("clear_all_blank", bad, 0);
    check("clear_overrun", overrun, 1);
    check("clear_addr", addr, 7'h00);

    // Reset in the middle of a sweep
    send(1, 8'h5A);
    send(0, 8'h01);
    repeat (10) @(posedge CLOCK_50);
    #1 Reset = 1'b1;
    @(posedge CLOCK_50); #1 Reset = 1'b0;
    check("rst_sweep_busy", busy, 0);
    check("rst_sweep_overrun", overrun, 0);
    check("rst_sweep_display", display_on, 0);
    count_non_blank(bad);
    check("rst_sweep_blank", bad, 0);
    @(posedge CLOCK_50); #1;
    check("rst_sweep_busy_stays", busy, 0);
    send(1, 8'h51);
    check("rst_id_default_inc", addr, 7'h01);
    check("rst_char_Q", characters[0][0], 8'h51);

`ifdef LCD_RESP_BUSY_TIMING_EN
    send(0, 8'h0C);
    bcount = 1;
    for (int i = 0; i < 200; i++) begin
      if (i == 2) begin LCD_RS = 1'b0; LCD_DATA = 8'h08; LCD_EN = 1'b1; end
      if (i == 3) LCD_EN = 1'b0;
      @(posedge CLOCK_50); #1;
      if (!busy) break;
      bcount++;
    end
    check("exec_busy_cycles", bcount, EXEC_T);
    check("exec_overrun", overrun, 1);
    check("exec_display_kept", display_on, 1);
`else
    send(0, 8'h0C);
    check("instr_not_busy", busy, 0);
    check("instr_no_overrun", overrun, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
